// File: rtl/adder_pkg.sv
// rtl/adder_pkg.sv - shared helpers and stage record pieces for pipelined_rca_adder
package adder_pkg;

  // Bits handled by each carry segment; guards against a zero stage count.
  function automatic int unsigned seg_w_calc(input int unsigned width, input int unsigned stages);
    return (stages == 0) ? width : width / stages;
  endfunction

  // Control part of a pipeline stage record: beat valid and the carry handed to the next segment.
  typedef struct packed {
    logic valid;
    logic carry;
  } stage_ctl_t;

  localparam stage_ctl_t STAGE_CTL_RST = '{valid: 1'b0, carry: 1'b0};

endpackage

// File: rtl/full_adder.sv
// rtl/full_adder.sv - single-bit full adder cell
module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/rca_segment.sv
// rtl/rca_segment.sv - combinational SEG_W-bit ripple-carry segment built from full_adder cells
module rca_segment #(
  parameter int unsigned SEG_W = 4
) (
  input  logic [SEG_W-1:0] a,
  input  logic [SEG_W-1:0] b,
  input  logic             ci,
  output logic [SEG_W-1:0] s,
  output logic             co,
  output logic             co_msb_in
);

  // w_c[i] is the carry into bit i; w_c[SEG_W] leaves the segment.
  logic [SEG_W:0] w_c;

  assign w_c[0] = ci;

  for (genvar i = 0; i < SEG_W; i++) begin : g_bit
    full_adder u_fa (
      .a  (a[i]),
      .b  (b[i]),
      .ci (w_c[i]),
      .s  (s[i]),
      .co (w_c[i+1])
    );
  end

  assign co        = w_c[SEG_W];
  // Carry into the segment MSB; only the top segment's value matters for signed overflow.
  assign co_msb_in = w_c[SEG_W-1];

endmodule

// File: rtl/pipelined_rca_adder.sv
// rtl/pipelined_rca_adder.sv - pipelined ripple-carry adder with valid/ready streaming; optional ovf via PIPELINED_RCA_OVF_EN
module pipelined_rca_adder
  import adder_pkg::*;
#(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned SEG_W = seg_w_calc(WIDTH, STAGES);

  if ((STAGES < 1) || (STAGES > WIDTH) || ((WIDTH % STAGES) != 0)) begin : g_cfg_err
    $error("pipelined_rca_adder: WIDTH must be a multiple of STAGES with 1 <= STAGES <= WIDTH");
  end

  // One pipeline slot: finished low sum bits, operands still to be added, and the pending carry.
  typedef struct packed {
    stage_ctl_t       ctl;
    logic [WIDTH-1:0] sum_lo;
    logic [WIDTH-1:0] a_hi;
    logic [WIDTH-1:0] b_hi;
  } stage_rec_t;

  localparam stage_rec_t REC_RST = '{ctl: STAGE_CTL_RST, sum_lo: '0, a_hi: '0, b_hi: '0};

  stage_rec_t r_stage [STAGES];
  stage_rec_t w_src   [STAGES];
  stage_rec_t w_next  [STAGES];
  logic       w_co_msb_in [STAGES];
  logic       w_adv;

  // The whole pipe moves together whenever the output slot is empty or being drained.
  assign w_adv    = !r_stage[STAGES-1].ctl.valid | out_ready;
  assign in_ready = w_adv;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [SEG_W-1:0] w_s;
    logic             w_co;
    stage_rec_t       w_rec;

    if (k == 0) begin : g_head
      assign w_src[k] = '{ctl: '{valid: in_valid, carry: cin}, sum_lo: '0, a_hi: a, b_hi: b};
    end else begin : g_body
      assign w_src[k] = r_stage[k-1];
    end

    rca_segment #(.SEG_W(SEG_W)) u_seg (
      .a         (w_src[k].a_hi[k*SEG_W +: SEG_W]),
      .b         (w_src[k].b_hi[k*SEG_W +: SEG_W]),
      .ci        (w_src[k].ctl.carry),
      .s         (w_s),
      .co        (w_co),
      .co_msb_in (w_co_msb_in[k])
    );

    // Fold this segment's sum bits and carry into the record passed to the next slot.
    always_comb begin
      w_rec                          = w_src[k];
      w_rec.ctl.carry                = w_co;
      w_rec.sum_lo[k*SEG_W +: SEG_W] = w_s;
    end

    assign w_next[k] = w_rec;
  end

  // Stage registers: cleared on reset (dropping in-flight beats), frozen as a whole while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < STAGES; i++) r_stage[i] <= REC_RST;
    end else if (w_adv) begin
      for (int i = 0; i < STAGES; i++) r_stage[i] <= w_next[i];
    end
  end

  assign out_valid = r_stage[STAGES-1].ctl.valid;
  assign sum       = r_stage[STAGES-1].sum_lo;
  assign cout      = r_stage[STAGES-1].ctl.carry;

`ifdef PIPELINED_RCA_OVF_EN
  logic r_ovf;
  logic w_ovf_next;

  // Signed overflow: carry into the MSB disagrees with carry out of it.
  assign w_ovf_next = w_co_msb_in[STAGES-1] ^ g_stage[STAGES-1].w_co;

  // Overflow flag travels with the final stage so it lines up with sum/cout.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf <= 1'b0;
    end else if (w_adv) begin
      r_ovf <= w_ovf_next;
    end
  end

  assign ovf = r_ovf & out_valid;
`else
  logic w_unused_msb;
  assign w_unused_msb = w_co_msb_in[STAGES-1];
  assign ovf          = 1'b0;
`endif

endmodule
